muldiv_alu_control: RTL and testbench

Parametrised ALU control unit that adds a multi-cycle multiply/divide engine with HI/LO registers. It sits between the main decoder and the execute stage. It decodes `alu_op_i`/`alu_function_i` into the 4-bit ALU operation code, runs MULT/MULTU/DIV/DIVU one bit per cycle, and serves MFHI/MFLO. It raises a stall to the pipeline while a dependent instruction must wait for the engine.

---
 rtl/muldiv_alu_control.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_alu_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu_control.sv
// ALU control unit with a bit-serial multiply/divide engine and HI/LO registers.
// Decodes {alu_op_i, alu_function_i} into a 4-bit ALU operation code. Runs
// MULT/MULTU/DIV/DIVU at one bit per cycle and serves MFHI/MFLO reads.
// Ports:
//   clk, reset                      - rising-edge clock, synchronous active-high reset
//   alu_op_i, alu_function_i        - class from main control and the funct field
//   issue_valid_i                   - the instruction in execute is valid
//   rs_data_i, rt_data_i            - operand A (multiplicand/dividend), operand B
//   alu_operation_o                 - ALU operation code (combinational)
//   hilo_sel_o, hilo_data_o         - result mux select for MFHI/MFLO and the HI/LO value
//   stall_o                         - hold the pipeline this cycle (combinational)
//   busy_o                          - engine is in RUN or FIX
module muldiv_alu_control #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [5:0]              alu_function_i,
  input  logic                    issue_valid_i,
  input  logic [DATA_WIDTH-1:0]   rs_data_i,
  input  logic [DATA_WIDTH-1:0]   rt_data_i,
  output logic [3:0]              alu_operation_o,
  output logic                    hilo_sel_o,
  output logic [DATA_WIDTH-1:0]   hilo_data_o,
  output logic                    stall_o,
  output logic                    busy_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [ALU_OP_WIDTH-1:0] OP_RTYPE = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADDI  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LUI   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ORI   = ALU_OP_WIDTH'(1);

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [2*W-1:0]  acc_q, acc_d;      // product, or quotient in the low half
  logic [W:0]      rem_q, rem_d;      // partial remainder for divide
  logic [W-1:0]    op2_q, op2_d;      // multiplicand magnitude or divisor magnitude
  logic [W-1:0]    rs_q, rs_d;        // raw dividend, returned in HI on divide by zero
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            rtype, is_muldiv, is_mfhi, is_mflo, accept;
  logic            op_div, op_signed, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W+1:0]    div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  // Instruction classification
  assign rtype     = (alu_op_i == OP_RTYPE);
  assign is_muldiv = (alu_function_i == FN_MULT) || (alu_function_i == FN_MULTU) ||
                     (alu_function_i == FN_DIV)  || (alu_function_i == FN_DIVU);
  assign is_mfhi   = (alu_function_i == FN_MFHI);
  assign is_mflo   = (alu_function_i == FN_MFLO);

  // ALU operation decode
  always_comb begin
    alu_operation_o = 4'b1001;
    if (rtype) begin
      case (alu_function_i)
        FN_ADD:   alu_operation_o = 4'b0011;
        FN_OR:    alu_operation_o = 4'b0001;
        FN_SLL:   alu_operation_o = 4'b0010;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
        FN_MFHI, FN_MFLO: alu_operation_o = 4'b1000;
        default:  alu_operation_o = 4'b1001;
      endcase
    end else begin
      case (alu_op_i)
        OP_ADDI: alu_operation_o = 4'b0011;
        OP_LUI:  alu_operation_o = 4'b0000;
        OP_ORI:  alu_operation_o = 4'b0001;
        default: alu_operation_o = 4'b1001;
      endcase
    end
  end

  // Pipeline handshake; stall implies busy, so accepts only happen in IDLE
  assign stall_o     = issue_valid_i & busy_q & rtype & (is_muldiv | is_mfhi | is_mflo);
  assign accept      = issue_valid_i & rtype & is_muldiv & ~stall_o;
  assign hilo_sel_o  = issue_valid_i & rtype & (is_mfhi | is_mflo);
  assign hilo_data_o = (rtype & is_mfhi) ? hi_q : lo_q;
  assign busy_o      = busy_q;

  // Operand magnitudes; funct bit 1 selects divide, bit 0 selects unsigned
  assign op_div    = alu_function_i[1];
  assign op_signed = ~alu_function_i[0];
  assign a_neg     = op_signed & rs_data_i[W-1];
  assign b_neg     = op_signed & rt_data_i[W-1];
  assign a_mag     = a_neg ? -rs_data_i : rs_data_i;
  assign b_mag     = b_neg ? -rt_data_i : rt_data_i;

  // One shift-add multiply step: add multiplicand to upper half when LSB set
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, op2_q} : (W+1)'(0));

  // One restoring divide step; the top bit of div_diff is the borrow
  assign div_shift = {rem_q[W-1:0], acc_q[W-1]};
  assign div_diff  = {rem_q, acc_q[W-1]} - (W+2)'(op2_q);

  // Sign correction applied in FIX; MIN / -1 wraps back to MIN with zero remainder
  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix   = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    op2_d     = op2_q;
    rs_d      = rs_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_d     = {W'(0), op_div ? a_mag : b_mag};
          op2_d     = op_div ? b_mag : a_mag;
          rem_d     = '0;
          rs_d      = rs_data_i;
          is_div_d  = op_div;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = op_div & (rt_data_i == '0);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_d[W-1:0] = {acc_q[W-2:0], ~div_diff[W+1]};
          rem_d        = div_diff[W+1] ? div_shift : div_diff[W:0];
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (is_div_q) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = rs_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      op2_q     <= '0;
      rs_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      op2_q     <= op2_d;
      rs_q      <= rs_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_alu_control.sv
// Scoreboard bench for muldiv_alu_control: reads of HI/LO push their expected
// value into a queue, and a monitor pops and compares whenever the DUT serves
// an unstalled MFHI/MFLO. Decode, busy length and stall timing are checked inline.
module tb_muldiv_alu_control;

  localparam int unsigned W = 32;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic         issue_valid;
  logic [W-1:0] rs_data, rt_data;
  logic [3:0]   alu_operation;
  logic         hilo_sel;
  logic [W-1:0] hilo_data;
  logic         stall;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  muldiv_alu_control #(.DATA_WIDTH(W), .ALU_OP_WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_op_i       (alu_op),
    .alu_function_i (funct),
    .issue_valid_i  (issue_valid),
    .rs_data_i      (rs_data),
    .rt_data_i      (rt_data),
    .alu_operation_o(alu_operation),
    .hilo_sel_o     (hilo_sel),
    .hilo_data_o    (hilo_data),
    .stall_o        (stall),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every unstalled MFHI/MFLO retires one scoreboard entry
  always @(negedge clk) begin
    if (!reset && issue_valid && hilo_sel && !stall) begin
      if (exp_q.size() == 0) begin
        check("hilo_read_unexpected", 64'(hilo_data), 64'hDEAD);
      end else begin
        check("hilo_read", 64'(hilo_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 1'b0;
    alu_op      = 3'b000;
    funct       = 6'b000000;
    rs_data     = '0;
    rt_data     = '0;
  endtask

  task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_valid = 1'b1;
    alu_op      = 3'b111;
    funct       = fn;
    rs_data     = a;
    rt_data     = b;
  endtask

  // Present MFHI/MFLO until it is no longer stalled
  task automatic read_hilo(input bit is_hi, input logic [W-1:0] exp);
    bit ok = 1'b0;
    exp_q.push_back(exp);
    issue(is_hi ? FN_MFHI : FN_MFLO, '0, '0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("read_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  // Issue one mul/div, time busy, check LO on the first idle cycle, then read both
  task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi_e, input logic [W-1:0] lo_e);
    int busy_cnt = 0;
    issue(fn, a, b);
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else break;
    end
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    check("lo_visible", 64'(hilo_data), 64'(lo_e));
    @(posedge clk); #1;
    read_hilo(1'b1, hi_e);
    read_hilo(1'b0, lo_e);
  endtask

  logic [2:0] t_op[10]  = '{3'b111, 3'b001, 3'b111, 3'b111, 3'b111, 3'b100, 3'b000, 3'b111, 3'b111, 3'b010};
  logic [5:0] t_fn[10]  = '{6'b100000, 6'b001010, 6'b111111, 6'b100101, 6'b000000,
                            6'b000101, 6'b011000, 6'b011000, 6'b010010, 6'b000000};
  logic       t_vld[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] t_exp[10] = '{4'b0011, 4'b0001, 4'b1001, 4'b0001, 4'b0010,
                            4'b0011, 4'b0000, 4'b1000, 4'b1000, 4'b1001};

  initial begin
    int stall_cnt;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", 64'(hilo_data), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_sel", 64'(hilo_sel), 64'd0);
    @(posedge clk); #1;

    // Decode table
    for (int i = 0; i < 10; i++) begin
      issue_valid = t_vld[i];
      alu_op      = t_op[i];
      funct       = t_fn[i];
      @(negedge clk);
      check($sformatf("decode_%0d", i), 64'(alu_operation), 64'(t_exp[i]));
      check($sformatf("decode_stall_%0d", i), 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Mul/div with issue_valid low is ignored
    issue(FN_MULT, 32'd3, 32'd3);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("invalid_ignored", 64'(busy), 64'd0);
    @(posedge clk); #1;

    run_op(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(FN_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op(FN_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);

    // MFLO held from cycle 1 stalls for the whole operation
    issue(FN_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    issue(FN_MFLO, '0, '0);
    exp_q.push_back(32'd14);
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      else break;
    end
    check("mflo_stall_cycles", 64'(stall_cnt), 64'(W + 1));
    check("mflo_sel", 64'(hilo_sel), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    read_hilo(1'b1, 32'd2);

    // Plain ALU op during busy does not stall
    issue(FN_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    issue(FN_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("add_busy", 64'(busy), 64'd1);
    check("add_no_stall", 64'(stall), 64'd0);
    check("add_decode", 64'(alu_operation), 64'd3);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle("add_wait_timeout");
    read_hilo(1'b0, 32'd14);

    // Reset in the middle of RUN
    run_op(FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    issue(FN_MULTU, 32'd3, 32'd3);
    @(posedge clk); #1;
    idle_inputs();
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_lo", 64'(hilo_data), 64'd0);
    @(posedge clk); #1;
    read_hilo(1'b1, 32'd0);
    run_op(FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
